// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between decode/branch-compare and the PC sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_W   = 8,
  parameter int JFIELD_W = 6,
  parameter int OFF_W    = 4
);
  logic                stall;
  logic                jump;
  logic                call;
  logic [JFIELD_W-1:0] jfield;
  logic                branch;
  logic                taken;
  logic [OFF_W-1:0]    boff;
  logic                jr;
  logic [ADDR_W-1:0]   jr_addr;
  logic                ret;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   pc_plus1;
  logic [ADDR_W-1:0]   link_addr;
  logic                redirect;
  logic                ras_empty;
  logic                ras_full;
  logic                ras_err;

  // Requester side (decode stage).
  modport master (
    output stall, jump, call, jfield, branch, taken, boff, jr, jr_addr, ret,
    input  pc, pc_plus1, link_addr, redirect, ras_empty, ras_full, ras_err
  );

  // Sequencer side.
  modport slave (
    input  stall, jump, call, jfield, branch, taken, boff, jr, jr_addr, ret,
    output pc, pc_plus1, link_addr, redirect, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with fixed-priority next-address select
// and a circular return-address stack for call/return.
module pc_sequencer #(
  parameter int               ADDR_W    = 8,
  parameter int               JFIELD_W  = 6,
  parameter int               OFF_W     = 4,
  parameter int               RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redir_q, redir_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              push;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic [ADDR_W-1:0] pc_plus1, br_tgt, j_tgt, boff_ext;
  logic [PTR_W-1:0]  top_ptr;

  assign pc_plus1 = pc_q + 1'b1;
  assign boff_ext = {{(ADDR_W-OFF_W){bus.boff[OFF_W-1]}}, bus.boff};
  assign br_tgt   = pc_plus1 + boff_ext;
  // Jumps stay inside the region of the following instruction.
  assign j_tgt    = {pc_plus1[ADDR_W-1:JFIELD_W], bus.jfield};
  // ptr points at the next free slot; the top lives just below it.
  assign top_ptr  = ptr_q - 1'b1;

  assign bus.pc        = pc_q;
  assign bus.pc_plus1  = pc_plus1;
  assign bus.link_addr = pc_plus1;
  assign bus.redirect  = redir_q;
  assign bus.ras_empty = (cnt_q == '0);
  assign bus.ras_full  = (cnt_q == CNT_FULL);
  assign bus.ras_err   = err_q;

  // Next-PC select by fixed priority; losing requests have no side effects.
  always_comb begin
    pc_d    = pc_q;
    redir_d = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push    = 1'b0;
    if (!bus.stall) begin
      pc_d = pc_plus1;
      if (bus.ret) begin
        // Underflow falls through as a plain sequential step.
        if (cnt_q == '0) begin
          err_d = 1'b1;
        end else begin
          pc_d    = ras_q[top_ptr];
          ptr_d   = top_ptr;
          cnt_d   = cnt_q - 1'b1;
          redir_d = 1'b1;
        end
      end else if (bus.jr) begin
        pc_d    = bus.jr_addr;
        redir_d = 1'b1;
      end else if (bus.jump) begin
        pc_d    = j_tgt;
        redir_d = 1'b1;
        if (bus.call) begin
          // When full, the write slot is the oldest entry, so it is overwritten.
          push  = 1'b1;
          ptr_d = ptr_q + 1'b1;
          if (cnt_q == CNT_FULL) err_d = 1'b1;
          else                   cnt_d = cnt_q + 1'b1;
        end
      end else if (bus.branch && bus.taken) begin
        pc_d    = br_tgt;
        redir_d = 1'b1;
      end
    end
  end

  // PC, redirect pulse and stack bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      redir_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      redir_q <= redir_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Stack storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push) ras_q[ptr_q] <= pc_plus1;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(8), .JFIELD_W(6), .OFF_W(4)) bus ();

  pc_sequencer #(
    .ADDR_W(8), .JFIELD_W(6), .OFF_W(4), .RAS_DEPTH(4), .RESET_VEC(8'h00)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.stall = 0; bus.jump = 0; bus.call = 0; bus.jfield = '0;
    bus.branch = 0; bus.taken = 0; bus.boff = '0;
    bus.jr = 0; bus.jr_addr = '0; bus.ret = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic jr_to(input logic [7:0] a);
    idle(); bus.jr = 1; bus.jr_addr = a; step(); idle();
  endtask

  task automatic do_call(input logic [5:0] jf);
    idle(); bus.jump = 1; bus.call = 1; bus.jfield = jf; step(); idle();
  endtask

  task automatic do_ret();
    idle(); bus.ret = 1; step(); idle();
  endtask

  logic [5:0] call_jf [5] = '{6'h01, 6'h08, 6'h10, 6'h18, 6'h20};
  logic [7:0] ret_pc  [4] = '{8'h19, 8'h11, 8'h09, 8'h02};

  initial begin
    idle();
    #1;
    chk("rst_pc", bus.pc, 8'h00);
    chk("rst_redir", bus.redirect, 1'b0);
    chk("rst_empty", bus.ras_empty, 1'b1);
    chk("rst_full", bus.ras_full, 1'b0);
    chk("rst_err", bus.ras_err, 1'b0);
    #10 rst_n = 1'b1;

    // free run
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("seq_pc", bus.pc, i);
      chk("seq_redir", bus.redirect, 1'b0);
      chk("seq_empty", bus.ras_empty, 1'b1);
    end

    // jump within region, single-cycle redirect, wrap
    jr_to(8'h43);
    chk("jr_pc", bus.pc, 8'h43);
    chk("jr_redir", bus.redirect, 1'b1);
    bus.jump = 1; bus.jfield = 6'b000100; step(); idle();
    chk("j_pc", bus.pc, 8'h44);
    chk("j_redir", bus.redirect, 1'b1);
    step();
    chk("j_after_pc", bus.pc, 8'h45);
    chk("j_after_redir", bus.redirect, 1'b0);
    jr_to(8'hFF);
    step();
    chk("wrap_pc", bus.pc, 8'h00);
    chk("wrap_redir", bus.redirect, 1'b0);

    // branches
    jr_to(8'h10);
    bus.branch = 1; bus.taken = 1; bus.boff = 4'b1110; step(); idle();
    chk("br_tk_pc", bus.pc, 8'h0F);
    chk("br_tk_redir", bus.redirect, 1'b1);
    jr_to(8'h10);
    bus.branch = 1; bus.taken = 0; bus.boff = 4'b1110; step(); idle();
    chk("br_nt_pc", bus.pc, 8'h11);
    chk("br_nt_redir", bus.redirect, 1'b0);
    jr_to(8'h10);
    bus.taken = 1; bus.boff = 4'b1110; step(); idle();
    chk("taken_only_pc", bus.pc, 8'h11);
    bus.call = 1; bus.jfield = 6'h30; step(); idle();
    chk("call_only_pc", bus.pc, 8'h12);
    chk("call_only_empty", bus.ras_empty, 1'b1);

    // call / return
    jr_to(8'h20);
    do_call(6'h30);
    chk("call_pc", bus.pc, 8'h30);
    chk("call_empty", bus.ras_empty, 1'b0);
    do_ret();
    chk("ret_pc", bus.pc, 8'h21);
    chk("ret_redir", bus.redirect, 1'b1);
    chk("ret_empty", bus.ras_empty, 1'b1);

    // overflow then drain
    for (int i = 0; i < 5; i++) begin
      do_call(call_jf[i]);
      chk("ovf_pc", bus.pc, {2'b00, call_jf[i]});
      if (i == 3) begin
        chk("full4", bus.ras_full, 1'b1);
        chk("err4", bus.ras_err, 1'b0);
      end
    end
    chk("full5", bus.ras_full, 1'b1);
    chk("err5", bus.ras_err, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_ret();
      chk("lifo_pc", bus.pc, ret_pc[i]);
      chk("lifo_redir", bus.redirect, 1'b1);
    end
    chk("drain_empty", bus.ras_empty, 1'b1);
    do_ret();
    chk("unf_pc", bus.pc, 8'h03);
    chk("unf_redir", bus.redirect, 1'b0);
    chk("unf_err", bus.ras_err, 1'b1);

    // stall over a full set of requests, then ret wins
    do_call(6'h05);
    chk("pre_stall_pc", bus.pc, 8'h05);
    bus.stall = 1; bus.ret = 1; bus.jr = 1; bus.jr_addr = 8'h77;
    bus.jump = 1; bus.call = 1; bus.jfield = 6'h3A;
    bus.branch = 1; bus.taken = 1; bus.boff = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_pc", bus.pc, 8'h05);
      chk("stall_redir", bus.redirect, 1'b0);
      chk("stall_empty", bus.ras_empty, 1'b0);
    end
    bus.stall = 0; step(); idle();
    chk("prio_pc", bus.pc, 8'h04);
    chk("prio_redir", bus.redirect, 1'b1);
    chk("prio_empty", bus.ras_empty, 1'b1);

    // async reset mid-cycle
    do_call(6'h07);
    chk("pre_rst_empty", bus.ras_empty, 1'b0);
    bus.jr = 1; bus.jr_addr = 8'h55;
    @(posedge clk); #2;
    idle();
    chk("pre_rst_pc", bus.pc, 8'h55);
    chk("pre_rst_redir", bus.redirect, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_pc", bus.pc, 8'h00);
    chk("arst_redir", bus.redirect, 1'b0);
    chk("arst_empty", bus.ras_empty, 1'b1);
    chk("arst_err", bus.ras_err, 1'b0);
    #10 rst_n = 1'b1;
    step();
    chk("post_rst_pc", bus.pc, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
